// File: rtl/demux_14_1_2_stream.sv
// rtl/demux_14_1_2_stream.sv - 14-bit 1-to-2 valid/ready stream demultiplexer with per-channel FIFOs
//
// Optional feature macro: DEMUX_STATS_EN (adds a_count / b_count delivery counters).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_data word, in_sel (0 -> A, 1 -> B)
//   a_valid/a_ready     channel A consumer handshake, a_data = head entry (0 when empty)
//   b_valid/b_ready     channel B consumer handshake, b_data = head entry (0 when empty)
//   a_count, b_count    words delivered per channel, wrap at 16 bits (DEMUX_STATS_EN only)

module demux_14_1_2_stream_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             pop;

    assign valid = (occ != '0);
    assign full  = (occ == OCC_W'(DEPTH));
    assign pop   = valid & ready;
    // Empty FIFO presents zero rather than stale storage.
    assign data  = valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: it is only observed through the occupancy gate.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave occupancy unchanged.
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end
endmodule

module demux_14_1_2_stream #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);
    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;
    logic accept;

    // Ready depends only on the selected channel's registered occupancy, so a
    // full channel refuses a word even while it is popping (no pass-through).
    assign in_ready = in_sel ? ~b_full : ~a_full;
    assign accept   = in_valid & in_ready;
    assign a_push   = accept & ~in_sel;
    assign b_push   = accept &  in_sel;

    demux_14_1_2_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (a_push),
        .push_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data),
        .full      (a_full)
    );

    demux_14_1_2_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push),
        .push_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data),
        .full      (b_full)
    );

`ifdef DEMUX_STATS_EN
    // Delivery counters: one count per pop, free-running wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_valid && a_ready) begin
                a_count <= a_count + 16'd1;
            end
            if (b_valid && b_ready) begin
                b_count <= b_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_demux_14_1_2_stream.sv
// tb/tb_demux_14_1_2_stream.sv - self-checking bench for demux_14_1_2_stream
module tb_demux_14_1_2_stream;
    localparam int WIDTH = 14;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
`ifdef DEMUX_STATS_EN
    logic [15:0]      a_count;
    logic [15:0]      b_count;
`endif

    demux_14_1_2_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_STATS_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             v;
        logic             sel;
        logic [WIDTH-1:0] d;
        logic             ar;
        logic             br;
        logic             e_rdy;
        logic             e_av;
        logic             e_bv;
    } vec_t;

    vec_t             vecs [$];
    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];
    logic [15:0]      cnt_a;
    logic [15:0]      cnt_b;
    int               n_checks;
    int               n_fail;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, v, sel, input logic [WIDTH-1:0] d,
                       input logic ar, br, e_rdy, e_av, e_bv);
        vec_t t;
        t.rst = rst; t.v = v; t.sel = sel; t.d = d; t.ar = ar; t.br = br;
        t.e_rdy = e_rdy; t.e_av = e_av; t.e_bv = e_bv;
        vecs.push_back(t);
    endtask

    // One cycle: drive after negedge, check against the scoreboard model (and
    // optionally hand-derived expectations), then advance the model at posedge.
    task automatic apply(input logic r, v, s, input logic [WIDTH-1:0] d,
                         input logic ar, br, has_exp, e_rdy, e_av, e_bv);
        logic             exp_rdy;
        logic             pop_a;
        logic             pop_b;
        logic [WIDTH-1:0] head_a;
        logic [WIDTH-1:0] head_b;
        reset = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        #1;
        exp_rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        head_a  = (qa.size() != 0) ? qa[0] : '0;
        head_b  = (qb.size() != 0) ? qb[0] : '0;
        chk("in_ready",  16'(in_ready), 16'(exp_rdy));
        chk("a_valid",   16'(a_valid),  16'(qa.size() != 0));
        chk("b_valid",   16'(b_valid),  16'(qb.size() != 0));
        chk("a_data",    16'(a_data),   16'(head_a));
        chk("b_data",    16'(b_data),   16'(head_b));
        if (has_exp) begin
            chk("vec_in_ready", 16'(in_ready), 16'(e_rdy));
            chk("vec_a_valid",  16'(a_valid),  16'(e_av));
            chk("vec_b_valid",  16'(b_valid),  16'(e_bv));
        end
`ifdef DEMUX_STATS_EN
        chk("a_count", a_count, cnt_a);
        chk("b_count", b_count, cnt_b);
`endif
        pop_a = (qa.size() != 0) && ar;
        pop_b = (qb.size() != 0) && br;
        @(posedge clk);
        if (r) begin
            qa.delete();
            qb.delete();
            cnt_a = '0;
            cnt_b = '0;
        end else begin
            if (pop_a) begin
                void'(qa.pop_front());
                cnt_a = cnt_a + 16'd1;
            end
            if (pop_b) begin
                void'(qb.pop_front());
                cnt_b = cnt_b + 16'd1;
            end
            if (v && exp_rdy) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cnt_a    = '0;
        cnt_b    = '0;

        //   rst v  sel data      ar br  rdy av bv
        // reset state
        add(0, 0, 0, 14'h0000, 1, 1,  1, 0, 0);
        // basic routing
        add(0, 1, 0, 14'h1234, 1, 1,  1, 0, 0);
        add(0, 1, 1, 14'h2ABC, 1, 1,  1, 1, 0);
        add(0, 0, 0, 14'h0000, 1, 1,  1, 0, 1);
        // backpressure / full on A
        add(0, 1, 0, 14'h0001, 0, 1,  1, 0, 0);
        add(0, 1, 0, 14'h0002, 0, 1,  1, 1, 0);
        add(0, 1, 0, 14'h0003, 0, 1,  0, 1, 0);
        add(0, 1, 0, 14'h0003, 0, 1,  0, 1, 0);
        // independence: B accepts while A is full and stalled
        add(0, 1, 1, 14'h3FFF, 0, 1,  1, 1, 0);
        // A full and popping still refuses the word
        add(0, 1, 0, 14'h0003, 1, 1,  0, 1, 1);
        add(0, 1, 0, 14'h0003, 1, 1,  1, 1, 0);
        add(0, 0, 0, 14'h0000, 1, 1,  1, 1, 0);
        // sustained push+pop at occupancy 1
        add(0, 1, 0, 14'h0100, 1, 1,  1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            add(0, 1, 0, 14'h0100 + 14'(i), 1, 1,  1, 1, 0);
        end
        add(0, 0, 0, 14'h0000, 1, 1,  1, 1, 0);
        // mid-operation reset with two words in each FIFO
        add(0, 1, 0, 14'h0AAA, 0, 0,  1, 0, 0);
        add(0, 1, 0, 14'h0AAB, 0, 0,  1, 1, 0);
        add(0, 1, 1, 14'h0BBB, 0, 0,  1, 1, 0);
        add(0, 1, 1, 14'h0BBC, 0, 0,  1, 1, 1);
        add(1, 1, 0, 14'h0CCC, 1, 1,  0, 1, 1);
        add(0, 0, 0, 14'h0000, 0, 0,  1, 0, 0);
        add(0, 1, 0, 14'h0DDD, 0, 0,  1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 1,  1, 1, 0);
        add(0, 0, 1, 14'h0000, 1, 1,  1, 0, 0);

        // Power-up reset held two cycles with in_valid high.
        reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 14'h1555;
        a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br,
                  1'b1, vecs[i].e_rdy, vecs[i].e_av, vecs[i].e_bv);
        end

        // Randomised traffic with occasional reset, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
                  WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Drain and confirm both channels empty out.
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_14_1_2_stream.md
Name: demux_14_1_2_stream

Overview:
- 14-bit 1-to-2 stream demultiplexer: the inverse of the 14-bit 2:1 select datapath.
- Routes one valid/ready input stream to output channel A or channel B, chosen per word by a select bit.
- Each channel has its own small FIFO, so a stalled channel does not block words already queued for the other.
- Sits between a single 14-bit producer and two independent 14-bit consumers in the HW4 datapath.

Parameters:
- WIDTH, 14, data width of input and both output channels.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  0 routes to A, 1 routes to B; sampled with in_data.
- a_valid  output  1  channel A head entry valid.
- a_ready  input  1  channel A consumer accepts.
- a_data  output  WIDTH  channel A head entry.
- b_valid  output  1  channel B head entry valid.
- b_ready  input  1  channel B consumer accepts.
- b_data  output  WIDTH  channel B head entry.
- a_count  output  16  words delivered on A (STATS_EN only).
- b_count  output  16  words delivered on B (STATS_EN only).

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; every register is updated only on the rising edge of clk.
- Reset:
  - both FIFOs are emptied (read pointer, write pointer and occupancy set to 0);
  - a_valid and b_valid are 0;
  - a_data and b_data read 0;
  - counters are 0.
- Reset takes priority over all concurrent push/pop activity. Words held in the FIFOs when reset is asserted are discarded, not delivered.
- Acceptance:
  - in_ready = (in_sel ? ~b_full : ~a_full), combinational from in_sel and registered occupancy only.
  - in_ready has no combinational path from a_ready or b_ready.
  - A transfer occurs when in_valid & in_ready at the clock edge; the word is written to the FIFO selected by in_sel.
- Full-FIFO rule: a full channel deasserts in_ready for words selected to it, even in a cycle where that channel is popping. One bubble is accepted; there is no pass-through when full.
- Latency: a word accepted at edge N is visible on x_valid/x_data after edge N; there is no zero-cycle bypass.
- Output handshake per channel x:
  - x_valid = occupancy != 0;
  - x_data = FIFO head entry, held stable while x_valid & ~x_ready;
  - pop on x_valid & x_ready.
- Simultaneous push and pop on the same non-full channel: occupancy is unchanged and both pointers advance.
- Channels are independent: A can pop while B is pushed, both in the same cycle.
- Ordering:
  - per-channel order is preserved;
  - no ordering is defined between A and B.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- When x_valid = 0, x_data is 0.
- in_sel and in_data are ignored whenever in_valid = 0.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - a_count and b_count are present;
  - each increments by 1 on every pop of its channel;
  - each wraps from 0xFFFF to 0x0000;
  - each clears on reset.
- Undefined:
  - a_count and b_count ports are absent;
  - no counter logic is generated;
  - all other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid = 1 -> a_valid = b_valid = 0, data = 0, in_ready = 1, counts = 0.
- Basic routing: push 0x1234 with sel = 0, then 0x2ABC with sel = 1, a_ready = b_ready = 1 -> a_data = 0x1234 one cycle after the first accept; b_data = 0x2ABC one cycle after the second accept; a_count = b_count = 1.
- Backpressure/full:
  - with a_ready = 0, push 0x0001, 0x0002, 0x0003 to A -> in_ready drops after 2 accepts;
  - raise a_ready -> A delivers 0x0001 then 0x0002 in order;
  - 0x0003 is accepted only after occupancy falls below DEPTH.
- Independence: A full with a_ready = 0, push 0x3FFF with sel = 1 -> in_ready = 1, and b_valid = 1 with 0x3FFF on the next cycle.
- Simultaneous push/pop on A at occupancy 1, sustained for 8 cycles -> occupancy stays at 1, output order matches input order, no drops.
- Mid-operation reset with both FIFOs holding 2 words -> after the edge both valids are 0, and the next word pushed to A after reset is the first one delivered.
